cnn_cell_mac: RTL and testbench



---
 rtl/cnn_pkg.sv | 33 +++
 rtl/cnn_sat.sv | 20 ++
 rtl/cnn_cell_mac.sv | 105 ++++++++++
 tb/tb_cnn_cell_mac.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and width helpers for the CNN cell MAC.
package cnn_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  function automatic int clog2(input int v);
    int r = 0;
    int x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int dw_of(input int width);
    return width + 1;
  endfunction

  // Headroom for TAPS feedback plus TAPS control products plus the bias.
  function automatic int acc_w_of(input int width, input int taps);
    return 2 * dw_of(width) + clog2(2 * taps + 1);
  endfunction

  function automatic int idx_w_of(input int taps);
    return (taps > 1) ? clog2(taps) : 1;
  endfunction

  function automatic int tap_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/cnn_sat.sv
// Signed clamp from IN_W to OUT_W bits, raising clip when the value is out of range.
module cnn_sat #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 17
) (
  input  logic signed [IN_W-1:0]  sum,
  output logic        [OUT_W-1:0] data,
  output logic                    clip
);

  logic fits;

  // In range exactly when all bits above the output sign bit replicate it.
  assign fits = (&sum[IN_W-1:OUT_W-1]) | ~(|sum[IN_W-1:OUT_W-1]);
  assign clip = ~fits;
  assign data = fits      ? sum[OUT_W-1:0] :
                sum[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                              {1'b0, {(OUT_W-1){1'b1}}};

endmodule

// File: rtl/cnn_cell_mac.sv
// Sequential CNN cell equation: sum(A*Y) + sum(B*U) + I, one tap per cycle.
// Build with CNN_MAC_SATURATE_EN to clamp the result; otherwise it wraps.
module cnn_cell_mac
  import cnn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAPS  = 9,
  parameter int OUT_W = 2 * WIDTH + 1
) (
  input  logic                           gclk,
  input  logic                           grst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [TAPS*dw_of(WIDTH)-1:0]   a_tpl,
  input  logic [TAPS*dw_of(WIDTH)-1:0]   b_tpl,
  input  logic [TAPS*dw_of(WIDTH)-1:0]   y_nbh,
  input  logic [TAPS*dw_of(WIDTH)-1:0]   u_nbh,
  input  logic signed [dw_of(WIDTH)-1:0] bias,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_sat
);

  localparam int DW    = dw_of(WIDTH);
  localparam int ACC_W = acc_w_of(WIDTH, TAPS);
  localparam int IDX_W = idx_w_of(TAPS);

  typedef struct packed {
    logic [TAPS-1:0][DW-1:0] a;
    logic [TAPS-1:0][DW-1:0] b;
    logic [TAPS-1:0][DW-1:0] y;
    logic [TAPS-1:0][DW-1:0] u;
  } opnd_t;

  state_t                   state;
  opnd_t                    op_q;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [2*DW-1:0]   pa;
  logic signed [2*DW-1:0]   pb;
  logic [OUT_W-1:0]         cv_data;
  logic                     cv_sat;

  assign pa  = $signed(op_q.a[idx]) * $signed(op_q.y[idx]);
  assign pb  = $signed(op_q.b[idx]) * $signed(op_q.u[idx]);
  assign sum = acc + ACC_W'(pa) + ACC_W'(pb);

  assign in_ready = (state == IDLE);

`ifdef CNN_MAC_SATURATE_EN
  cnn_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat (
    .sum  (sum),
    .data (cv_data),
    .clip (cv_sat)
  );
`else
  assign cv_data = OUT_W'(sum);
  assign cv_sat  = 1'b0;
`endif

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int k = 0; k < TAPS; k++) begin
            op_q.a[k] <= a_tpl[tap_lsb(k, DW) +: DW];
            op_q.b[k] <= b_tpl[tap_lsb(k, DW) +: DW];
            op_q.y[k] <= y_nbh[tap_lsb(k, DW) +: DW];
            op_q.u[k] <= u_nbh[tap_lsb(k, DW) +: DW];
          end
          acc   <= ACC_W'(bias);
          idx   <= '0;
          state <= ACC;
        end
        ACC: begin
          acc <= sum;
          idx <= idx + 1'b1;
          // Last tap: the converted result is taken straight from the adder.
          if (idx == IDX_W'(TAPS - 1)) begin
            out_data  <= cv_data;
            out_sat   <= cv_sat;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_cell_mac.sv
// Directed checks of cnn_cell_mac: latency, packing, wrap/clamp, stall, reset, capture.
module tb_cnn_cell_mac;

  localparam int WIDTH = 8;
  localparam int TAPS  = 9;
  localparam int DW    = WIDTH + 1;
  localparam int OUT_W = 2 * WIDTH + 1;

  logic                    gclk = 1'b0;
  logic                    grst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [TAPS*DW-1:0]      a_tpl = '0;
  logic [TAPS*DW-1:0]      b_tpl = '0;
  logic [TAPS*DW-1:0]      y_nbh = '0;
  logic [TAPS*DW-1:0]      u_nbh = '0;
  logic signed [DW-1:0]    bias = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  int n_chk  = 0;
  int n_fail = 0;

  cnn_cell_mac #(.WIDTH(WIDTH), .TAPS(TAPS), .OUT_W(OUT_W)) dut (
    .gclk      (gclk),
    .grst_n    (grst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_tpl     (a_tpl),
    .b_tpl     (b_tpl),
    .y_nbh     (y_nbh),
    .u_nbh     (u_nbh),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input int a, input int b, input int y, input int u, input int bi);
    logic [31:0] va, vb, vy, vu, vi;
    va = a; vb = b; vy = y; vu = u; vi = bi;
    for (int k = 0; k < TAPS; k++) begin
      a_tpl[k*DW +: DW] = va[DW-1:0];
      b_tpl[k*DW +: DW] = vb[DW-1:0];
      y_nbh[k*DW +: DW] = vy[DW-1:0];
      u_nbh[k*DW +: DW] = vu[DW-1:0];
    end
    bias = vi[DW-1:0];
  endtask

  // Present operands for one accept edge (block must be idle).
  task automatic accept(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    @(posedge gclk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge gclk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, TAPS);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge gclk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    @(negedge gclk) grst_n = 1'b1;
    @(posedge gclk); #1;
    chk("rst_in_ready", in_ready, 1);

    // All ones: 9 + 9 = 18
    set_all(1, 1, 1, 1, 0);
    accept("ones");
    wait_out("ones");
    chk("ones_data", out_data, 18);
    chk("ones_sat", out_sat, 0);
    take("ones");

    // A[k]=k+1 with Y=1: 45 - 5 = 40
    set_all(0, 0, 1, 0, -5);
    for (int k = 0; k < TAPS; k++) begin
      logic [31:0] v;
      v = k + 1;
      a_tpl[k*DW +: DW] = v[DW-1:0];
    end
    accept("ramp");
    wait_out("ramp");
    chk("ramp_data", out_data, 40);
    take("ramp");

    // 18 * 65536 = 1179648, out of range for 17 signed bits
    set_all(-256, -256, -256, -256, 0);
    accept("big");
    wait_out("big");
`ifdef CNN_MAC_SATURATE_EN
    chk("big_data", out_data, 65535);
    chk("big_sat", out_sat, 1);
`else
    chk("big_data", out_data, 0);
    chk("big_sat", out_sat, 0);
`endif
    take("big");

    // Stall in DONE: 9*2*2*2 + 1 = 73, held while inputs churn
    set_all(2, 2, 2, 2, 1);
    accept("stall");
    wait_out("stall");
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      set_all(c, -c, 3, c + 1, c);
      @(negedge gclk);
      chk("stall_data", out_data, 73);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    set_all(1, 1, 1, 1, 0);
    @(posedge gclk); #1;
    take("stall");
    // in_valid still high: next edge accepts the all-ones set
    @(posedge gclk); #1;
    in_valid = 1'b0;
    chk("stall_next_busy", in_ready, 0);
    wait_out("stall_next");
    chk("stall_next_data", out_data, 18);
    take("stall_next");

    // Reset in the middle of accumulation
    set_all(7, 7, 7, 7, 7);
    accept("rst");
    repeat (3) @(posedge gclk);
    #1 grst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_sat", out_sat, 0);
    @(negedge gclk) grst_n = 1'b1;
    repeat (12) @(negedge gclk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    @(posedge gclk); #1;
    set_all(1, 1, 1, 1, 3);
    accept("after_rst");
    wait_out("after_rst");
    chk("after_rst_data", out_data, 21);
    take("after_rst");

    // Operands change right after accept; captured copy is what counts
    set_all(1, 1, 1, 1, 0);
    accept("cap");
    set_all(5, 5, 5, 5, 100);
    wait_out("cap");
    chk("cap_data", out_data, 18);
    take("cap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
